// File: rtl/dma_pkg.sv
// Shared DMA definitions: FSM state codes, transfer size codes
// and a helper that turns a size code into a byte count.
package dma_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_POP  = 3'd1;
  localparam logic [2:0] ST_REQ  = 3'd2;
  localparam logic [2:0] ST_RSP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  function automatic logic [2:0] size_bytes(
    input logic [2:0] sz
  );
    logic [2:0] n;
    case (sz)
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dma_size_sel.sv
// Picks the largest naturally aligned access that fits.
// Ports: addr_lo_i (addr[1:0]), rem_i (bytes left), size_o.
module dma_size_sel
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [1:0]       addr_lo_i,
  input  logic [LEN_W-1:0] rem_i,
  output logic [2:0]       size_o
);

  logic rem_one;
  logic rem_lt4;

  assign rem_one = (rem_i == LEN_W'(1));
  assign rem_lt4 = (rem_i < LEN_W'(4));

  always_comb begin
    if (addr_lo_i[0] || rem_one) begin
      size_o = SZ_BYTE;
    end else if (addr_lo_i[1] || rem_lt4) begin
      size_o = SZ_HALF;
    end else begin
      size_o = SZ_WORD;
    end
  end

endmodule

// File: rtl/dma_wr_engine.sv
// DMA write engine: pops FIFO bytes, issues aligned writes.
// Ports: job ctl/status, FIFO drain port, write req/rsp bus.
module dma_wr_engine
  import dma_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              aborted_o,
  output logic              fifo_wvalid_o,
  input  logic              fifo_wready_i,
  output logic [2:0]        fifo_wsize_o,
  output logic [1:0]        fifo_wladdr_o,
  input  logic [31:0]       fifo_wdata_i,
  input  logic [3:0]        fifo_wstrb_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [2:0]        req_size_o,
  output logic [31:0]       req_wdata_o,
  output logic [3:0]        req_wstrb_o,
  input  logic              rsp_valid_i,
  input  logic              rsp_err_i
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        rstrb_q, rstrb_d;
  logic              err_q, err_d;
  logic              abt_q, abt_d;
  logic              pend_q, pend_d;

  logic [2:0] size;
  logic [2:0] step;
  logic       in_pop;

  dma_size_sel #(
    .LEN_W (LEN_W)
  ) u_size (
    .addr_lo_i (addr_q[1:0]),
    .rem_i     (rem_q),
    .size_o    (size)
  );

  assign step   = size_bytes(size);
  assign in_pop = (state_q == ST_POP);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    raddr_d = raddr_q;
    rsize_d = rsize_q;
    rdata_d = rdata_q;
    rstrb_d = rstrb_q;
    err_d   = err_q;
    abt_d   = abt_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_d  = 1'b0;
          abt_d  = 1'b0;
          pend_d = 1'b0;
          addr_d = dst_addr_i;
          rem_d  = len_i;
          if (len_i == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_POP;
          end
        end
      end
      ST_POP: begin
        // abort wins so the FIFO never loses bytes
        if (abort_i) begin
          abt_d   = 1'b1;
          state_d = ST_DONE;
        end else if (fifo_wready_i) begin
          raddr_d = addr_q;
          rsize_d = size;
          rdata_d = fifo_wdata_i;
          rstrb_d = fifo_wstrb_i;
          addr_d  = addr_q + ADDR_W'(step);
          rem_d   = rem_q - LEN_W'(step);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (abort_i) pend_d = 1'b1;
        if (req_ready_i) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (abort_i) pend_d = 1'b1;
        if (rsp_valid_i) begin
          if (rsp_err_i) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (abort_i || pend_q) begin
            abt_d   = 1'b1;
            state_d = ST_DONE;
          end else if (rem_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_POP;
          end
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        abt_d   = 1'b0;
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      raddr_q <= '0;
      rsize_q <= '0;
      rdata_q <= '0;
      rstrb_q <= '0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      raddr_q <= raddr_d;
      rsize_q <= rsize_d;
      rdata_q <= rdata_d;
      rstrb_q <= rstrb_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
      pend_q  <= pend_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign err_o     = done_o && err_q;
  assign aborted_o = done_o && abt_q;

  assign fifo_wvalid_o = in_pop && !abort_i;
  assign fifo_wsize_o  = in_pop ? size : SZ_BYTE;
  assign fifo_wladdr_o = in_pop ? addr_q[1:0] : 2'b00;

  assign req_valid_o = (state_q == ST_REQ);
  assign req_addr_o  = raddr_q;
  assign req_size_o  = rsize_q;
  assign req_wdata_o = rdata_q;
  assign req_wstrb_o = rstrb_q;

endmodule
